// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive/transmit paths.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    ARP,
    WAIT_END,
    FINISH,
    DROP
  } eth_rx_state_t;

  // Byte enables for an MSB-first word holding n valid bytes.
  function automatic logic [3:0] keep_from_count(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 update register, shared by the RX and TX paths.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_nxt;

  always_comb begin
    crc_nxt = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ CRC32_POLY) : (crc_nxt >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst)       crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc_nxt;
  end

endmodule

// File: rtl/eth_rx.sv
// GMII receive path: deframes, filters Ethernet/IPv4/UDP/ARP, streams UDP payload.
// Define ETH_RX_CRC_CHECK_EN to include FCS checking.
//
// state    | meaning
// IDLE     | waiting for a preamble byte
// PREAMBLE | consuming 0x55 bytes until SFD
// ETH_HDR  | dest/src MAC and ethertype
// IP_HDR   | 20-byte IPv4 header
// UDP_HDR  | 8-byte UDP header
// PAYLOAD  | packing UDP payload into 32-bit words
// ARP      | 28-byte ARP body into shadow registers
// WAIT_END | padding and FCS until dv drops
// FINISH   | one cycle after the final word / ARP result
// DROP     | discarding the frame until dv drops
module eth_rx
  import eth_pkg::*;
#(
  parameter int MAX_UDP_PAYLOAD = 1472
) (
  input  logic        gmii_rx_clk,
  input  logic        gmii_rx_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [47:0] mac_s_addr,
  input  logic [31:0] ip_s_addr,
  input  logic [15:0] port_s,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [47:0] rx_mac_s_addr,
  output logic [31:0] rx_ip_s_addr,
  output logic [15:0] rx_port_s,
  output logic        arp_rx_done,
  output logic        arp_oper,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa,
  output logic        frame_drop
);

  eth_rx_state_t state, state_nxt;

  logic [10:0] cnt;
  logic [39:0] sh;
  logic [15:0] udp_len;
  logic [15:0] udp_pay;
  logic [10:0] pay_len;
  logic [31:0] word;
  logic [2:0]  wbytes;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;
  logic        arp_oper_sh;
  logic [47:0] arp_sha_sh;
  logic [31:0] arp_spa_sh;
  logic        is_arp;
  logic        err;
  logic        wait_idle;
  logic        crc_bad;
  logic        frame_bad;

  logic        cnt_clr, hdr_pass, fin, trunc, drop_pulse;
  logic        last_byte;
  logic [1:0]  lane;
  logic [15:0] w16;
  logic [31:0] w32;
  logic [47:0] w48;

  assign w16       = {sh[7:0], gmii_rxd};
  assign w32       = {sh[23:0], gmii_rxd};
  assign w48       = {sh[39:0], gmii_rxd};
  assign lane      = cnt[1:0];
  assign last_byte = (cnt == pay_len - 11'd1);
  assign udp_pay   = udp_len - 16'd8;
  assign frame_bad = err | crc_bad;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc;
  logic        crc_init, crc_en;

  assign crc_init = (state == PREAMBLE) && gmii_rx_dv && (gmii_rxd == ETH_SFD);
  assign crc_en   = gmii_rx_dv &&
                    (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, ARP, WAIT_END});

  eth_crc32_d8 u_crc (
    .clk  (gmii_rx_clk),
    .rst  (gmii_rx_rst),
    .init (crc_init),
    .en   (crc_en),
    .data (gmii_rxd),
    .crc  (crc)
  );

  assign crc_bad = (crc != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge gmii_rx_clk) begin
    if (gmii_rx_rst) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    hdr_pass  = 1'b0;
    fin       = 1'b0;
    trunc     = 1'b0;
    case (state)
      IDLE:
        if (gmii_rx_dv && !wait_idle)
          state_nxt = (gmii_rxd == ETH_PREAMBLE) ? PREAMBLE : DROP;
      PREAMBLE:
        if (!gmii_rx_dv || (gmii_rxd != ETH_PREAMBLE && gmii_rxd != ETH_SFD)) begin
          state_nxt = DROP;
        end else if (gmii_rxd == ETH_SFD) begin
          state_nxt = ETH_HDR;
          cnt_clr   = 1'b1;
        end
      ETH_HDR:
        if (!gmii_rx_dv) begin
          state_nxt = DROP;
        end else if (cnt == 11'd5 && w48 != mac_s_addr && w48 != 48'hFFFF_FFFF_FFFF) begin
          state_nxt = DROP;
        end else if (cnt == 11'd13) begin
          cnt_clr = 1'b1;
          if (w16 == ETHERTYPE_IPV4)     state_nxt = IP_HDR;
          else if (w16 == ETHERTYPE_ARP) state_nxt = ARP;
          else                           state_nxt = DROP;
        end
      IP_HDR:
        if (!gmii_rx_dv ||
            (cnt == 11'd0 && gmii_rxd != 8'h45) ||
            (cnt == 11'd9 && gmii_rxd != IP_PROTO_UDP) ||
            (cnt == 11'd19 && w32 != ip_s_addr)) begin
          state_nxt = DROP;
        end else if (cnt == 11'd19) begin
          state_nxt = UDP_HDR;
          cnt_clr   = 1'b1;
        end
      UDP_HDR:
        if (!gmii_rx_dv || (cnt == 11'd3 && w16 != port_s)) begin
          state_nxt = DROP;
        end else if (cnt == 11'd7) begin
          if (udp_len <= 16'd8 || udp_pay > 16'(MAX_UDP_PAYLOAD)) begin
            state_nxt = DROP;
          end else begin
            state_nxt = PAYLOAD;
            cnt_clr   = 1'b1;
            hdr_pass  = 1'b1;
          end
        end
      PAYLOAD:
        if (!gmii_rx_dv) begin
          state_nxt = FINISH;
          trunc     = 1'b1;
        end else if (last_byte) begin
          state_nxt = WAIT_END;
        end
      ARP:
        if (!gmii_rx_dv ||
            (cnt == 11'd1 && w16 != 16'h0001) ||
            (cnt == 11'd3 && w16 != ETHERTYPE_IPV4) ||
            (cnt == 11'd4 && gmii_rxd != 8'd6) ||
            (cnt == 11'd5 && gmii_rxd != 8'd4) ||
            (cnt == 11'd7 && w16 != 16'h0001 && w16 != 16'h0002) ||
            (cnt == 11'd27 && w32 != ip_s_addr)) begin
          state_nxt = DROP;
        end else if (cnt == 11'd27) begin
          state_nxt = WAIT_END;
        end
      WAIT_END:
        if (!gmii_rx_dv) begin
          state_nxt = FINISH;
          fin       = 1'b1;
        end
      FINISH:   state_nxt = IDLE;
      DROP:     if (!gmii_rx_dv) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    drop_pulse = (state_nxt == DROP && state != DROP) || (fin && is_arp && frame_bad);
  end

  // Result registers are updated on the edge that enters FINISH so the final
  // word and ARP pulse appear one cycle after dv is first seen low.
  always_ff @(posedge gmii_rx_clk) begin
    if (gmii_rx_rst) begin
      wait_idle     <= 1'b1;
      cnt           <= '0;
      sh            <= '0;
      err           <= 1'b0;
      is_arp        <= 1'b0;
      udp_len       <= '0;
      pay_len       <= '0;
      word          <= '0;
      wbytes        <= '0;
      src_mac       <= '0;
      src_ip        <= '0;
      src_port      <= '0;
      arp_oper_sh   <= 1'b0;
      arp_sha_sh    <= '0;
      arp_spa_sh    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      rx_mac_s_addr <= '0;
      rx_ip_s_addr  <= '0;
      rx_port_s     <= '0;
      arp_rx_done   <= 1'b0;
      arp_oper      <= 1'b0;
      arp_sha       <= '0;
      arp_spa       <= '0;
      frame_drop    <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      arp_rx_done   <= 1'b0;
      frame_drop    <= drop_pulse;

      if (!gmii_rx_dv) wait_idle <= 1'b0;
      if (gmii_rx_dv)  sh <= {sh[31:0], gmii_rxd};

      if (cnt_clr)         cnt <= '0;
      else if (gmii_rx_dv) cnt <= cnt + 11'd1;

      if (state == IDLE)                  err <= gmii_rx_dv & gmii_rx_er;
      else if (gmii_rx_dv && gmii_rx_er)  err <= 1'b1;

      if (gmii_rx_dv) begin
        case (state)
          ETH_HDR: begin
            if (cnt == 11'd11) src_mac <= w48;
            if (cnt == 11'd13) is_arp  <= (w16 == ETHERTYPE_ARP);
          end
          IP_HDR:
            if (cnt == 11'd15) src_ip <= w32;
          UDP_HDR: begin
            if (cnt == 11'd1) src_port <= w16;
            if (cnt == 11'd5) udp_len  <= w16;
          end
          PAYLOAD: begin
            case (lane)
              2'd0:    word         <= {gmii_rxd, 24'h0};
              2'd1:    word[23:16]  <= gmii_rxd;
              2'd2:    word[15:8]   <= gmii_rxd;
              default: word[7:0]    <= gmii_rxd;
            endcase
            wbytes <= (lane == 2'd3 && !last_byte) ? 3'd0 : {1'b0, lane} + 3'd1;
            if (lane == 2'd3 && !last_byte) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {word[31:8], gmii_rxd};
              m_axis_tkeep  <= 4'hF;
            end
          end
          ARP: begin
            if (cnt == 11'd7)  arp_oper_sh <= (w16 == 16'h0001);
            if (cnt == 11'd13) arp_sha_sh  <= w48;
            if (cnt == 11'd17) arp_spa_sh  <= w32;
          end
          default: ;
        endcase
      end

      if (hdr_pass) begin
        rx_mac_s_addr <= src_mac;
        rx_ip_s_addr  <= src_ip;
        rx_port_s     <= src_port;
        pay_len       <= udp_pay[10:0];
      end

      if ((fin && !is_arp) || trunc) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= word;
        m_axis_tkeep  <= keep_from_count(wbytes);
        m_axis_tlast  <= 1'b1;
        m_axis_tuser  <= trunc | frame_bad;
      end

      if (fin && is_arp && !frame_bad) begin
        arp_rx_done <= 1'b1;
        arp_oper    <= arp_oper_sh;
        arp_sha     <= arp_sha_sh;
        arp_spa     <= arp_spa_sh;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: directed GMII frames, monitor pops expected words.
module tb_eth_rx;

  localparam logic [47:0] LMAC  = 48'hAABBCCDDEEFF;
  localparam logic [31:0] LIP   = 32'hC0A80102;
  localparam logic [15:0] LPORT = 16'h1234;
  localparam logic [47:0] RMAC  = 48'h001122334455;
  localparam logic [31:0] RIP   = 32'hC0A80101;
  localparam logic [15:0] RPORT = 16'h5678;
`ifdef ETH_RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic        gmii_rx_clk = 1'b0;
  logic        gmii_rx_rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [47:0] mac_s_addr;
  logic [31:0] ip_s_addr;
  logic [15:0] port_s;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [47:0] rx_mac_s_addr;
  logic [31:0] rx_ip_s_addr;
  logic [15:0] rx_port_s;
  logic        arp_rx_done;
  logic        arp_oper;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic        frame_drop;

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  eth_rx #(.MAX_UDP_PAYLOAD(1472)) dut (
    .gmii_rx_clk   (gmii_rx_clk),
    .gmii_rx_rst   (gmii_rx_rst),
    .gmii_rxd      (gmii_rxd),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .mac_s_addr    (mac_s_addr),
    .ip_s_addr     (ip_s_addr),
    .port_s        (port_s),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .rx_mac_s_addr (rx_mac_s_addr),
    .rx_ip_s_addr  (rx_ip_s_addr),
    .rx_port_s     (rx_port_s),
    .arp_rx_done   (arp_rx_done),
    .arp_oper      (arp_oper),
    .arp_sha       (arp_sha),
    .arp_spa       (arp_spa),
    .frame_drop    (frame_drop)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } word_t;

  typedef struct {
    logic        oper;
    logic [47:0] sha;
    logic [31:0] spa;
  } arp_t;

  word_t      exp_q[$];
  arp_t       arp_q[$];
  logic [7:0] frm[$];
  int         tests = 0;
  int         fails = 0;
  int         drop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic push_be(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) frm.push_back(v[8*k +: 8]);
  endtask

  task automatic eth_hdr(input logic [47:0] dmac, input logic [15:0] etype);
    frm.delete();
    push_be(64'(dmac), 6);
    push_be(64'(RMAC), 6);
    push_be(64'(etype), 2);
  endtask

  task automatic finish_frame(input logic flip);
    logic [31:0] c;
    logic [31:0] fcs;
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (frm[k]) c = crc_upd(c, frm[k]);
    fcs = ~c;
    if (flip) fcs = fcs ^ 32'h0000_0100;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
  endtask

  task automatic build_udp(input logic [47:0] dmac, input logic [15:0] dport,
                           input int plen, input logic flip);
    eth_hdr(dmac, 16'h0800);
    push_be(64'h4500, 2);
    push_be(64'(28 + plen), 2);
    push_be(64'h0000_4000, 4);
    push_be(64'h4011_0000, 4);
    push_be(64'(RIP), 4);
    push_be(64'(LIP), 4);
    push_be(64'(RPORT), 2);
    push_be(64'(dport), 2);
    push_be(64'(8 + plen), 2);
    push_be(64'h0, 2);
    for (int k = 1; k <= plen; k++) frm.push_back(8'(k));
    finish_frame(flip);
  endtask

  task automatic build_arp();
    eth_hdr(48'hFFFF_FFFF_FFFF, 16'h0806);
    push_be(64'h0001_0800_0604_0001, 8);
    push_be(64'(RMAC), 6);
    push_be(64'(RIP), 4);
    push_be(64'h0, 6);
    push_be(64'(LIP), 4);
    finish_frame(1'b0);
  endtask

  // Frame byte indices start at the destination MAC; -1 disables an option.
  task automatic send_frame(input int er_idx, input int trunc_len, input int rst_idx);
    int n;
    n = (trunc_len >= 0) ? trunc_len : frm.size();
    for (int k = 0; k < 8; k++) begin
      @(negedge gmii_rx_clk);
      gmii_rx_dv = 1'b1;
      gmii_rx_er = 1'b0;
      gmii_rxd   = (k == 7) ? 8'hD5 : 8'h55;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge gmii_rx_clk);
      gmii_rxd    = frm[k];
      gmii_rx_er  = (k == er_idx);
      gmii_rx_rst = (k == rst_idx);
    end
    @(negedge gmii_rx_clk);
    gmii_rx_dv  = 1'b0;
    gmii_rx_er  = 1'b0;
    gmii_rx_rst = 1'b0;
    gmii_rxd    = 8'h00;
    repeat (16) @(negedge gmii_rx_clk);
  endtask

  task automatic exp_word(input logic [31:0] d, input logic [3:0] k,
                          input logic l, input logic u);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    w.user = u;
    exp_q.push_back(w);
  endtask

  always @(posedge gmii_rx_clk) begin : monitor
    word_t       e;
    arp_t        a;
    logic [31:0] msk;
    #1;
    if (m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got tdata %h tkeep %h, required no output",
                 m_axis_tdata, m_axis_tkeep);
      end else begin
        e = exp_q.pop_front();
        for (int b = 0; b < 4; b++) msk[8*b +: 8] = {8{e.keep[b]}};
        chk("tdata", 64'(m_axis_tdata & msk), 64'(e.data & msk));
        chk("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
        chk("tlast", 64'(m_axis_tlast), 64'(e.last));
        if (e.last) chk("tuser", 64'(m_axis_tuser), 64'(e.user));
      end
    end
    if (frame_drop) drop_cnt++;
    if (arp_rx_done) begin
      if (arp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_arp: got arp_rx_done 1, required 0");
      end else begin
        a = arp_q.pop_front();
        chk("arp_oper", 64'(arp_oper), 64'(a.oper));
        chk("arp_sha", 64'(arp_sha), 64'(a.sha));
        chk("arp_spa", 64'(arp_spa), 64'(a.spa));
      end
    end
  end

  initial begin
    arp_t a;
    gmii_rx_rst = 1'b1;
    gmii_rx_dv  = 1'b0;
    gmii_rx_er  = 1'b0;
    gmii_rxd    = 8'h00;
    mac_s_addr  = LMAC;
    ip_s_addr   = LIP;
    port_s      = LPORT;
    repeat (4) @(negedge gmii_rx_clk);
    gmii_rx_rst = 1'b0;
    @(negedge gmii_rx_clk);

    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'h0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'h0);
    chk("rst_frame_drop", 64'(frame_drop), 64'h0);
    chk("rst_arp_done", 64'(arp_rx_done), 64'h0);
    chk("rst_rx_ip", 64'(rx_ip_s_addr), 64'h0);
    chk("rst_arp_sha", 64'(arp_sha), 64'h0);

    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05060708, 4'hF, 1'b1, 1'b0);
    build_udp(LMAC, LPORT, 8, 1'b0);
    send_frame(-1, -1, -1);
    chk("udp8_rx_ip", 64'(rx_ip_s_addr), 64'(RIP));
    chk("udp8_rx_port", 64'(rx_port_s), 64'(RPORT));
    chk("udp8_rx_mac", 64'(rx_mac_s_addr), 64'(RMAC));
    chk("udp8_drops", 64'(drop_cnt), 64'd0);

    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05000000, 4'h8, 1'b1, 1'b0);
    build_udp(LMAC, LPORT, 5, 1'b0);
    send_frame(-1, -1, -1);

    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05060708, 4'hF, 1'b1, CRC_EN);
    build_udp(LMAC, LPORT, 8, 1'b1);
    send_frame(-1, -1, -1);

    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05060708, 4'hF, 1'b1, 1'b1);
    build_udp(LMAC, LPORT, 8, 1'b0);
    send_frame(44, -1, -1);
    chk("rx_er_drops", 64'(drop_cnt), 64'd0);

    build_udp(LMAC, 16'h9999, 8, 1'b0);
    send_frame(-1, -1, -1);
    chk("port_filter_drops", 64'(drop_cnt), 64'd1);

    build_udp(48'h112233445566, LPORT, 8, 1'b0);
    send_frame(-1, -1, -1);
    chk("mac_filter_drops", 64'(drop_cnt), 64'd2);

    a.oper = 1'b1;
    a.sha  = RMAC;
    a.spa  = RIP;
    arp_q.push_back(a);
    build_arp();
    send_frame(-1, -1, -1);
    chk("arp_drops", 64'(drop_cnt), 64'd2);
    chk("arp_pending", 64'(arp_q.size()), 64'd0);

    build_udp(LMAC, LPORT, 8, 1'b0);
    send_frame(-1, -1, 44);
    chk("rst_mid_rx_ip", 64'(rx_ip_s_addr), 64'h0);
    chk("rst_mid_arp_sha", 64'(arp_sha), 64'h0);
    chk("rst_mid_drops", 64'(drop_cnt), 64'd2);
    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05060708, 4'hF, 1'b1, 1'b0);
    build_udp(LMAC, LPORT, 8, 1'b0);
    send_frame(-1, -1, -1);
    chk("after_rst_rx_ip", 64'(rx_ip_s_addr), 64'(RIP));

    exp_word(32'h01020304, 4'hF, 1'b0, 1'b0);
    exp_word(32'h05060000, 4'hC, 1'b1, 1'b1);
    build_udp(LMAC, LPORT, 8, 1'b0);
    send_frame(-1, 48, -1);
    chk("trunc_drops", 64'(drop_cnt), 64'd2);

    chk("words_outstanding", 64'(exp_q.size()), 64'd0);
    chk("arp_outstanding", 64'(arp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_rx.md
# eth_rx

GMII receive path of the Ethernet stack, the receive-side counterpart of `eth_tx`. It deframes GMII bytes (preamble/SFD), filters and parses the Ethernet, IPv4 and UDP headers, and checks the FCS. UDP payload is delivered as a 32-bit AXI-Stream with per-frame error status. Received ARP packets are decoded into sender fields for the ARP responder.

## Interface
- `MAX_UDP_PAYLOAD`, 1472: largest accepted UDP payload in bytes; frames with a larger `udp_len-8` are dropped.
- `gmii_rx_clk  in  1`: the only clock; the output stream is synchronous to it.
- `gmii_rx_rst  in  1`: synchronous, active-high reset.
- `gmii_rxd  in  8`: receive data.
- `gmii_rx_dv  in  1`: receive data valid.
- `gmii_rx_er  in  1`: receive error.
- `mac_s_addr  in  48`: local MAC address.
- `ip_s_addr  in  32`: local IP address.
- `port_s  in  16`: local UDP port.
- `m_axis_tdata  out  32`: payload word; first received byte in [31:24].
- `m_axis_tkeep  out  4`: byte enables; bit 3 corresponds to [31:24].
- `m_axis_tvalid  out  1`: word valid. There is no tready; the sink must always accept.
- `m_axis_tlast  out  1`: last word of the frame.
- `m_axis_tuser  out  1`: frame error, meaningful only with tlast.
- `rx_mac_s_addr  out  48`: remote (sender) MAC.
- `rx_ip_s_addr  out  32`: remote (sender) IP.
- `rx_port_s  out  16`: remote (sender) UDP port.
- `arp_rx_done  out  1`: one-cycle pulse on a good ARP packet.
- `arp_oper  out  1`: 1 = request (oper 0x0001), 0 = reply (0x0002).
- `arp_sha  out  48`: ARP sender hardware address.
- `arp_spa  out  32`: ARP sender protocol address.
- `frame_drop  out  1`: one-cycle pulse when a frame is filtered out or malformed.

## Operation
States: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, ARP, WAIT_END, FINISH, DROP.

- **IDLE**
  - `gmii_rx_dv`=1 with 0x55 -> PREAMBLE.
  - `gmii_rx_dv`=1 with any other byte -> DROP.
- **PREAMBLE**
  - 0x55 -> stay.
  - 0xD5 -> ETH_HDR, byte counter cleared.
  - Anything else -> DROP.
- **ETH_HDR** (14 bytes)
  - Destination must equal `mac_s_addr` or FF:FF:FF:FF:FF:FF; the source is latched.
  - Ethertype 0x0800 -> IP_HDR; 0x0806 -> ARP; otherwise DROP.
- **IP_HDR** (20 bytes)
  - Requires version 4, IHL 5, protocol 17 and destination equal to `ip_s_addr`; the source IP is latched.
  - Any mismatch -> DROP.
- **UDP_HDR** (8 bytes)
  - Destination port must equal `port_s`; the source port and `udp_len` are latched.
  - Payload length = `udp_len-8`. Zero, or greater than `MAX_UDP_PAYLOAD` -> DROP.
  - On pass, `rx_mac_s_addr`, `rx_ip_s_addr` and `rx_port_s` update together.
- **PAYLOAD**
  - Bytes are packed MSB-first into a 4-byte word.
  - Each full word except the final one is emitted with tkeep=F, tlast=0.
  - The final (possibly partial) word is held; after the last payload byte -> WAIT_END.
  - Ethernet padding bytes are ignored.
- **ARP** (28 bytes)
  - htype 1, ptype 0x0800, hlen 6, plen 4 and TPA equal to `ip_s_addr` are required, else DROP.
  - oper, SHA and SPA are latched into shadow registers -> WAIT_END.
- **WAIT_END**: consumes padding and FCS until `gmii_rx_dv`=0 -> FINISH.
- **FINISH** (1 cycle)
  - For UDP: emit the held word with tlast=1 and tkeep = ones for the valid bytes (1 byte -> 8, 2 -> C, 3 -> E, 4 -> F).
  - For ARP: if no error, copy the shadow registers to `arp_*` and pulse `arp_rx_done`; on error pulse `frame_drop`.
  - Then -> IDLE.
- **DROP**: pulses `frame_drop` once on entry and waits for `gmii_rx_dv`=0 -> IDLE. No stream output.
- **Error flag**: set by `gmii_rx_er`=1 on any in-frame byte, or by a CRC failure; sets `m_axis_tuser` on the last word.
- **Truncation**
  - `gmii_rx_dv` falling during PAYLOAD -> FINISH, emitting the partial word with tlast=1, tuser=1.
  - `gmii_rx_dv` falling before PAYLOAD or ARP completes -> DROP behaviour (`frame_drop` pulse, no stream).
- **Reset mid-frame**: returns to IDLE and all outputs to 0. The rest of the in-progress frame is ignored until `gmii_rx_dv` goes low; the next preamble is then parsed normally.

## Timing
- Reset values: all outputs 0.
- Latency:
  - A non-final word has `m_axis_tvalid` high one cycle after its 4th byte is sampled.
  - The final word has `m_axis_tvalid` high one cycle after the first sample with `gmii_rx_dv`=0.
  - `arp_rx_done` follows the same timing as the final word.
- `m_axis_tvalid`, `arp_rx_done` and `frame_drop` are single-cycle pulses.
- `arp_*` outputs are stable between pulses.
- The minimum 12-byte IFG guarantees FINISH completes before the next preamble.

## Configuration
`ETH_RX_CRC_CHECK_EN`:
- **Defined**:
  - Reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF) runs over bytes from the destination MAC through the FCS.
  - At frame end, a register value other than 0xDEBB20E3 sets the error flag: tuser=1 for UDP; ARP is discarded and `frame_drop` pulses.
- **Undefined**: no CRC logic. The error flag comes from `gmii_rx_er` and truncation only.

## Structure
- `eth_pkg` holds:
  - ETHERTYPE_IPV4 and ETHERTYPE_ARP;
  - IP_PROTO_UDP;
  - ETH_PREAMBLE (0x55) and ETH_SFD (0xD5);
  - CRC32_POLY, CRC32_INIT and CRC32_RESIDUE;
  - the `eth_rx_state_t` enum.
- Sub-module `eth_crc32_d8`: byte-wide CRC update (`clk`, `rst`, `init`, `en`, `data[7:0]`, `crc[31:0]`), shareable with the transmit side.

## Test plan
In every scenario: local MAC AABBCCDDEEFF, IP C0A80102, port 1234.

- **UDP, 8-byte payload**: frame from 001122334455 / C0A80101:5678 with payload 01..08 and good FCS -> words 0x01020304 (tkeep F, tlast 0) then 0x05060708 (tkeep F, tlast 1, tuser 0); `rx_ip_s_addr`=C0A80101, `rx_port_s`=5678.
- **UDP, 5-byte payload (padded frame)**: payload 01..05 -> words 0x01020304, then 0x05xxxxxx with tkeep 8, tlast 1; padding not emitted.
- **Error cases**:
  - With `ETH_RX_CRC_CHECK_EN`, a flipped FCS bit -> last word tuser=1.
  - `gmii_rx_er` asserted on payload byte 3 -> tuser=1.
- **Filtered frames**: destination port 0x9999, or destination MAC 112233445566 -> no tvalid, one `frame_drop` pulse.
- **ARP request**: SHA 001122334455, SPA C0A80101, TPA C0A80102 -> `arp_rx_done` pulse, `arp_oper`=1, `arp_sha`/`arp_spa` equal to those values.
- **Recovery**:
  - `gmii_rx_rst` asserted mid-payload, then a good frame -> no output from the aborted frame; the second frame is delivered intact.
  - Payload truncated after 6 bytes -> second word with tkeep C, tlast 1, tuser 1.
